mem_access_unit: RTL and testbench

- Stage-4 load/store unit, the consumer end of the execute stage.
- Takes the effective address (execute `alu_result_o`) and the forwarded store data (execute `write_data_o`).
- Runs one request/grant/response transaction on the data-memory port and returns aligned, extended load data for write-back.
- Stalls the pipeline while a transaction is outstanding; reports load/store misaligned and access-fault exceptions.

---
 rtl/mem_access_unit_pkg.sv | 43 ++++
 rtl/mem_access_unit_if.sv | 28 ++
 rtl/mem_access_unit_lsu_data_align.sv | 41 ++++
 rtl/mem_access_unit.sv | 177 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM-stage load/store unit: access sizes, FSM states,
// exception codes and the alignment helpers used by the top and datapath.
package mem_access_unit_pkg;

    localparam int LSU_XLEN = 32;
    localparam int LSU_STRB = LSU_XLEN / 8;

    typedef enum logic [1:0] {
        LSU_B = 2'b00,
        LSU_H = 2'b01,
        LSU_W = 2'b10
    } lsu_size_e;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN,
        DONE
    } lsu_state_e;

    typedef enum logic [2:0] {
        NO_EXCEPTION,
        LOAD_MISALIGNED,
        STORE_MISALIGNED,
        LOAD_ACCESS_FAULT,
        STORE_ACCESS_FAULT
    } exc_type_e;

    // The 2'b11 encoding behaves as a word access.
    function automatic lsu_size_e decode_size(input logic [1:0] size);
        case (size)
            2'b00:   return LSU_B;
            2'b01:   return LSU_H;
            default: return LSU_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] addr_lo);
        return ((size == LSU_H) && addr_lo[0]) || ((size == LSU_W) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory port between the load/store unit (master) and the memory (slave).
interface mem_access_unit_if #(
    parameter int XLEN = 32
);
    // req/we/addr/wdata/wstrb are held stable from req rise until the cycle gnt
    // is seen high; rvalid (with rdata/err) answers the granted request no
    // earlier than the cycle after gnt, and only one request is ever outstanding.
    logic            dmem_req_o;
    logic            dmem_gnt_i;
    logic            dmem_we_o;
    logic [XLEN-1:0] dmem_addr_o;
    logic [XLEN-1:0] dmem_wdata_o;
    logic [3:0]      dmem_wstrb_o;
    logic            dmem_rvalid_i;
    logic [XLEN-1:0] dmem_rdata_i;
    logic            dmem_err_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i, dmem_err_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o,
        output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i, dmem_err_i
    );

endinterface

// File: rtl/mem_access_unit_lsu_data_align.sv
// Combinational lane logic: store byte-lane replication with strobes, and
// load word shift plus sign/zero extension.
module lsu_data_align
    import mem_access_unit_pkg::*;
(
    input  lsu_size_e            i_size,
    input  logic                 i_unsigned,
    input  logic [1:0]           i_addr_lo,
    input  logic [LSU_XLEN-1:0]  i_st_data,
    input  logic [LSU_XLEN-1:0]  i_ld_word,
    output logic [LSU_XLEN-1:0]  o_st_wdata,
    output logic [LSU_STRB-1:0]  o_st_strb,
    output logic [LSU_XLEN-1:0]  o_ld_data
);

    logic [LSU_XLEN-1:0] w_shifted;

    assign w_shifted = i_ld_word >> {i_addr_lo, 3'b000};

    always_comb begin
        o_st_wdata = i_st_data;
        o_st_strb  = 4'b1111;
        o_ld_data  = w_shifted;
        case (i_size)
            LSU_B: begin
                o_st_wdata = {4{i_st_data[7:0]}};
                o_st_strb  = 4'b0001 << i_addr_lo;
                o_ld_data  = i_unsigned ? {24'h0, w_shifted[7:0]}
                                        : {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            LSU_H: begin
                o_st_wdata = {2{i_st_data[15:0]}};
                o_st_strb  = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_ld_data  = i_unsigned ? {16'h0, w_shifted[15:0]}
                                        : {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one request/grant/response transaction per access,
// pipeline stall while outstanding, misaligned and access-fault reporting.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = LSU_XLEN
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      lsu_req_i,
    input  logic                      lsu_we_i,
    input  logic [1:0]                lsu_size_i,
    input  logic                      lsu_unsigned_i,
    input  logic                      flush_i,
    input  logic [XLEN-1:0]           addr_i,
    input  logic [XLEN-1:0]           wdata_i,
    output logic                      lsu_stall_o,
    output logic                      lsu_done_o,
    output logic [XLEN-1:0]           ld_data_o,
    output exc_type_e                 exc_type_o,
    mem_access_unit_if.master         dmem,
    output lsu_state_e                dbg_state_o
);

    lsu_state_e      r_state;
    lsu_state_e      w_next_state;
    logic            r_we;
    lsu_size_e       r_size;
    logic            r_unsigned;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [3:0]      r_strb;
    logic            r_err;
    logic [XLEN-1:0] r_ld_data;

    lsu_size_e       w_size;
    logic            w_misaligned;
    logic            w_accept;
    logic            w_capture;
    logic            w_in_req;
    logic [XLEN-1:0] w_st_wdata;
    logic [3:0]      w_st_strb;
    logic [XLEN-1:0] w_ld_data;
    logic [XLEN-1:0] w_unused_st_ld;
    logic [XLEN-1:0] w_unused_ld_wdata;
    logic [3:0]      w_unused_ld_strb;

    assign w_size       = decode_size(lsu_size_i);
    assign w_misaligned = is_misaligned(w_size, addr_i[1:0]);

    lsu_data_align u_store_align (
        .i_size     (w_size),
        .i_unsigned (1'b0),
        .i_addr_lo  (addr_i[1:0]),
        .i_st_data  (wdata_i),
        .i_ld_word  ('0),
        .o_st_wdata (w_st_wdata),
        .o_st_strb  (w_st_strb),
        .o_ld_data  (w_unused_st_ld)
    );

    lsu_data_align u_load_align (
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_addr_lo  (r_addr[1:0]),
        .i_st_data  ('0),
        .i_ld_word  (dmem.dmem_rdata_i),
        .o_st_wdata (w_unused_ld_wdata),
        .o_st_strb  (w_unused_ld_strb),
        .o_ld_data  (w_ld_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        lsu_stall_o     = 1'b0;
        lsu_done_o      = 1'b0;
        exc_type_o      = NO_EXCEPTION;
        dmem.dmem_req_o = 1'b0;
        w_accept        = 1'b0;
        w_capture       = 1'b0;
        case (r_state)
            IDLE: begin
                if (lsu_req_i && !flush_i) begin
                    if (w_misaligned) begin
                        // Rejected without touching the bus; completes this cycle.
                        lsu_done_o = 1'b1;
                        exc_type_o = lsu_we_i ? STORE_MISALIGNED : LOAD_MISALIGNED;
                    end else begin
                        w_accept     = 1'b1;
                        lsu_stall_o  = 1'b1;
                        w_next_state = REQ;
                    end
                end
            end
            REQ: begin
                lsu_stall_o     = 1'b1;
                dmem.dmem_req_o = 1'b1;
                if (dmem.dmem_gnt_i) begin
                    w_next_state = flush_i ? DRAIN : WAIT;
                end else if (flush_i) begin
                    w_next_state = IDLE;
                end
            end
            WAIT: begin
                lsu_stall_o = 1'b1;
                if (dmem.dmem_rvalid_i) begin
                    if (flush_i) begin
                        w_next_state = IDLE;
                    end else begin
                        w_capture    = 1'b1;
                        w_next_state = DONE;
                    end
                end else if (flush_i) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                // A granted request must still be answered before the port is reused.
                lsu_stall_o = 1'b1;
                if (dmem.dmem_rvalid_i) begin
                    w_next_state = IDLE;
                end
            end
            DONE: begin
                lsu_done_o   = !flush_i;
                if (r_err) begin
                    exc_type_o = r_we ? STORE_ACCESS_FAULT : LOAD_ACCESS_FAULT;
                end
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we       <= 1'b0;
            r_size     <= LSU_B;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_strb     <= 4'b0000;
            r_err      <= 1'b0;
            r_ld_data  <= '0;
        end else begin
            if (w_accept) begin
                r_we       <= lsu_we_i;
                r_size     <= w_size;
                r_unsigned <= lsu_unsigned_i;
                r_addr     <= addr_i;
                r_wdata    <= lsu_we_i ? w_st_wdata : '0;
                r_strb     <= lsu_we_i ? w_st_strb : 4'b0000;
            end
            if (w_capture) begin
                r_err     <= dmem.dmem_err_i;
                r_ld_data <= (r_we || dmem.dmem_err_i) ? '0 : w_ld_data;
            end
        end
    end

    assign w_in_req          = (r_state == REQ);
    assign dmem.dmem_we_o    = w_in_req & r_we;
    assign dmem.dmem_addr_o  = w_in_req ? {r_addr[XLEN-1:2], 2'b00} : '0;
    assign dmem.dmem_wdata_o = w_in_req ? r_wdata : '0;
    assign dmem.dmem_wstrb_o = w_in_req ? r_strb : 4'b0000;
    assign ld_data_o         = r_ld_data;
    assign dbg_state_o       = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and random accesses against a bus model,
// completions compared against a queue of expected {exception, load data}.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int W = 35;

    logic        clk_i;
    logic        rst_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [1:0]  lsu_size_i;
    logic        lsu_unsigned_i;
    logic        flush_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        lsu_stall_o;
    logic        lsu_done_o;
    logic [31:0] ld_data_o;
    exc_type_e   exc_type_o;
    lsu_state_e  dbg_state_o;

    mem_access_unit_if #(.XLEN(32)) dmem_bus ();

    mem_access_unit #(.XLEN(32)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .lsu_req_i      (lsu_req_i),
        .lsu_we_i       (lsu_we_i),
        .lsu_size_i     (lsu_size_i),
        .lsu_unsigned_i (lsu_unsigned_i),
        .flush_i        (flush_i),
        .addr_i         (addr_i),
        .wdata_i        (wdata_i),
        .lsu_stall_o    (lsu_stall_o),
        .lsu_done_o     (lsu_done_o),
        .ld_data_o      (ld_data_o),
        .exc_type_o     (exc_type_o),
        .dmem           (dmem_bus),
        .dbg_state_o    (dbg_state_o)
    );

    // ---- clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---- scoreboard
    logic [W-1:0] exp_q[$];
    logic [31:0]  exp_last_ld;
    int           n_vec;
    int           n_err;

    task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_i) begin
        logic [W-1:0] exp_w;
        if (!rst_i && lsu_done_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_done", 36'(lsu_done_o), 36'd0);
            end else begin
                exp_w = exp_q.pop_front();
                check_eq("done_result", 36'({exc_type_o, ld_data_o}), 36'(exp_w));
            end
        end
    end

    // ---- reference model
    function automatic logic model_misal(input logic [1:0] size, input logic [31:0] a);
        return ((size == 2'b01) && a[0]) || (size[1] && (a[1:0] != 2'b00));
    endfunction

    function automatic logic [3:0] model_strb(input logic [1:0] size, input logic [31:0] a);
        case (size)
            2'b00:   return 4'b0001 << a[1:0];
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] a, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[8*a[1:0] +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        case (size)
            2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return d;
        endcase
    endfunction

    // ---- driver tasks
    task automatic drive_idle();
        lsu_req_i              = 1'b0;
        lsu_we_i               = 1'b0;
        lsu_size_i             = 2'b00;
        lsu_unsigned_i         = 1'b0;
        flush_i                = 1'b0;
        addr_i                 = '0;
        wdata_i                = '0;
        dmem_bus.dmem_gnt_i    = 1'b0;
        dmem_bus.dmem_rvalid_i = 1'b0;
        dmem_bus.dmem_rdata_i  = '0;
        dmem_bus.dmem_err_i    = 1'b0;
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        lsu_req_i      = 1'b1;
        lsu_we_i       = we;
        lsu_size_i     = size;
        lsu_unsigned_i = uns;
        addr_i         = addr;
        wdata_i        = wdata;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_stall"}, 36'(lsu_stall_o), 36'd0);
        check_eq({tag, "_done"},  36'(lsu_done_o), 36'd0);
        check_eq({tag, "_ld"},    36'(ld_data_o), 36'd0);
        check_eq({tag, "_exc"},   36'(exc_type_o), 36'(NO_EXCEPTION));
        check_eq({tag, "_req"},   36'(dmem_bus.dmem_req_o), 36'd0);
        check_eq({tag, "_bus"},   36'({dmem_bus.dmem_we_o, dmem_bus.dmem_wstrb_o, dmem_bus.dmem_addr_o}), 36'd0);
        check_eq({tag, "_wdata"}, 36'(dmem_bus.dmem_wdata_o), 36'd0);
        check_eq({tag, "_state"}, 36'(dbg_state_o), 36'(IDLE));
    endtask

    task automatic lsu_access(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int gnt_lat, input int rv_lat,
                              input logic [31:0] rdata, input logic err);
        logic [2:0]  exc;
        logic [31:0] ld;
        @(posedge clk_i); #1;
        drive_req(we, size, uns, addr, wdata);
        if (model_misal(size, addr)) begin
            exc = we ? STORE_MISALIGNED : LOAD_MISALIGNED;
            exp_q.push_back({exc, exp_last_ld});
            @(negedge clk_i);
            check_eq("mis_done",  36'(lsu_done_o), 36'd1);
            check_eq("mis_stall", 36'(lsu_stall_o), 36'd0);
            check_eq("mis_req",   36'(dmem_bus.dmem_req_o), 36'd0);
            @(posedge clk_i); #1;
            lsu_req_i = 1'b0;
            @(negedge clk_i);
            check_eq("mis_state", 36'(dbg_state_o), 36'(IDLE));
            return;
        end
        if (err) begin
            exc = we ? STORE_ACCESS_FAULT : LOAD_ACCESS_FAULT;
            ld  = '0;
        end else begin
            exc = NO_EXCEPTION;
            ld  = we ? 32'h0 : model_load(size, uns, addr, rdata);
        end
        exp_q.push_back({exc, ld});
        exp_last_ld = ld;
        @(negedge clk_i);
        check_eq("t0_stall", 36'(lsu_stall_o), 36'd1);
        check_eq("t0_req",   36'(dmem_bus.dmem_req_o), 36'd0);
        @(posedge clk_i); #1;
        lsu_req_i = 1'b0;
        addr_i    = $urandom();
        wdata_i   = $urandom();
        for (int i = 0; i <= gnt_lat; i++) begin
            dmem_bus.dmem_gnt_i = (i == gnt_lat);
            @(negedge clk_i);
            check_eq("req_req",   36'(dmem_bus.dmem_req_o), 36'd1);
            check_eq("req_we",    36'(dmem_bus.dmem_we_o), 36'(we));
            check_eq("req_addr",  36'(dmem_bus.dmem_addr_o), 36'({addr[31:2], 2'b00}));
            check_eq("req_strb",  36'(dmem_bus.dmem_wstrb_o), we ? 36'(model_strb(size, addr)) : 36'd0);
            if (we) check_eq("req_wdata", 36'(dmem_bus.dmem_wdata_o), 36'(model_wdata(size, wdata)));
            check_eq("req_stall", 36'({lsu_stall_o, lsu_done_o}), 36'b10);
            @(posedge clk_i); #1;
        end
        dmem_bus.dmem_gnt_i = 1'b0;
        for (int j = 0; j <= rv_lat; j++) begin
            dmem_bus.dmem_rvalid_i = (j == rv_lat);
            dmem_bus.dmem_rdata_i  = (j == rv_lat) ? rdata : $urandom();
            dmem_bus.dmem_err_i    = (j == rv_lat) ? err : 1'b0;
            @(negedge clk_i);
            check_eq("wait_stall", 36'({lsu_stall_o, lsu_done_o, dmem_bus.dmem_req_o}), 36'b100);
            @(posedge clk_i); #1;
        end
        dmem_bus.dmem_rvalid_i = 1'b0;
        dmem_bus.dmem_err_i    = 1'b0;
        @(negedge clk_i);
        check_eq("done_pulse", 36'({lsu_done_o, lsu_stall_o}), 36'b10);
        @(posedge clk_i); #1;
    endtask

    // ---- stimulus
    initial begin
        n_vec       = 0;
        n_err       = 0;
        exp_last_ld = '0;
        drive_idle();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_all_zero("reset");
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Minimum-latency word load, then sub-word loads with extension.
        lsu_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0);
        check_eq("lw_ld", 36'(ld_data_o), 36'h0DEADBEEF);
        lsu_access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 0, 32'h80112233, 1'b0);
        check_eq("lb_ld", 36'(ld_data_o), 36'h0FFFFFF80);
        lsu_access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0, 0, 32'h80112233, 1'b0);
        check_eq("lbu_ld", 36'(ld_data_o), 36'h000000080);
        lsu_access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 1, 0, 32'h80112233, 1'b0);
        check_eq("lh_ld", 36'(ld_data_o), 36'h0FFFF8011);

        // Stores: lane replication and strobes (stores complete with load data 0).
        lsu_access(1'b1, 2'b00, 1'b0, 32'h201, 32'h000000A5, 0, 1, 32'h0, 1'b0);
        lsu_access(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000BEEF, 0, 0, 32'h0, 1'b0);

        // Misaligned accesses.
        lsu_access(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 0, 0, 32'h0, 1'b0);
        lsu_access(1'b1, 2'b01, 1'b0, 32'h303, 32'h1234, 0, 0, 32'h0, 1'b0);

        // Grant held off three cycles, then an error response.
        lsu_access(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 3, 2, 32'hCAFEF00D, 1'b1);
        check_eq("err_ld", 36'(ld_data_o), 36'd0);

        // Flush while waiting for the response: drain, no completion.
        @(posedge clk_i); #1;
        drive_req(1'b0, 2'b10, 1'b0, 32'h180, 32'h0);
        @(posedge clk_i); #1;
        lsu_req_i           = 1'b0;
        dmem_bus.dmem_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        dmem_bus.dmem_gnt_i = 1'b0;
        flush_i             = 1'b1;
        @(negedge clk_i);
        check_eq("fw_wait", 36'({dbg_state_o, lsu_stall_o}), 36'({WAIT, 1'b1}));
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        @(negedge clk_i);
        check_eq("fw_drain", 36'({dbg_state_o, lsu_stall_o, lsu_done_o}), 36'({DRAIN, 2'b10}));
        @(posedge clk_i); #1;
        dmem_bus.dmem_rvalid_i = 1'b1;
        dmem_bus.dmem_rdata_i  = 32'h55AA55AA;
        @(negedge clk_i);
        check_eq("fw_rvalid", 36'({dbg_state_o, lsu_done_o}), 36'({DRAIN, 1'b0}));
        @(posedge clk_i); #1;
        dmem_bus.dmem_rvalid_i = 1'b0;
        @(negedge clk_i);
        check_eq("fw_idle", 36'({dbg_state_o, lsu_stall_o, lsu_done_o}), 36'({IDLE, 2'b00}));
        check_eq("fw_ld_hold", 36'(ld_data_o), 36'(exp_last_ld));

        // Flush in REQ before grant: request withdrawn next cycle.
        @(posedge clk_i); #1;
        drive_req(1'b1, 2'b10, 1'b0, 32'h400, 32'h11223344);
        @(posedge clk_i); #1;
        lsu_req_i = 1'b0;
        flush_i   = 1'b1;
        @(negedge clk_i);
        check_eq("fr_req", 36'(dmem_bus.dmem_req_o), 36'd1);
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        @(negedge clk_i);
        check_eq("fr_drop", 36'({dbg_state_o, dmem_bus.dmem_req_o, lsu_stall_o, lsu_done_o}), 36'({IDLE, 3'b000}));

        // Reset while waiting: back to IDLE, late response ignored.
        @(posedge clk_i); #1;
        drive_req(1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
        @(posedge clk_i); #1;
        lsu_req_i           = 1'b0;
        dmem_bus.dmem_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        dmem_bus.dmem_gnt_i = 1'b0;
        rst_i               = 1'b1;
        @(posedge clk_i); #1;
        rst_i       = 1'b0;
        exp_last_ld = '0;
        @(negedge clk_i);
        check_all_zero("rst_wait");
        @(posedge clk_i); #1;
        dmem_bus.dmem_rvalid_i = 1'b1;
        dmem_bus.dmem_rdata_i  = 32'h12345678;
        @(negedge clk_i);
        check_eq("rst_late_rv", 36'({dbg_state_o, lsu_done_o}), 36'({IDLE, 1'b0}));
        @(posedge clk_i); #1;
        dmem_bus.dmem_rvalid_i = 1'b0;

        // Random mix of sizes, alignments, latencies and errors.
        for (int k = 0; k < 24; k++) begin
            lsu_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       32'h1000 | 32'($urandom_range(0, 255)), $urandom(),
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom(),
                       ($urandom_range(0, 7) == 0));
        end

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("sb_empty", 36'(exp_q.size()), 36'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
